id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage sitting directly upstream of the execute ALU.
- Captures decoded instruction fields each cycle and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operation select and both ALU operands.
- Detects load-use hazards and inserts bubbles; honours external stall and flush.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, shift-amount masking and
// load-use bubble insertion, feeding the execute-stage ALU.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_alu_sel,
  input  logic              id_a_pc,
  input  logic              id_b_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic [4:0]        ALUSignal,
  output logic [XLEN-1:0]   AiA,
  output logic [XLEN-1:0]   AiB,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  localparam logic [4:0] ALU_SLL = 5'd2;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;

  logic              valid_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   rs1_data_r;
  logic [XLEN-1:0]   rs2_data_r;
  logic [XLEN-1:0]   imm_r;
  logic [REG_AW-1:0] rs1_addr_r;
  logic [REG_AW-1:0] rs2_addr_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic [4:0]        alu_sel_r;
  logic              a_pc_r;
  logic              b_imm_r;
  logic              reg_write_r;
  logic              mem_read_r;
  logic              mem_write_r;

  logic              load_use_s;
  logic              bubble_s;
  logic [XLEN-1:0]   fwd_rs1_s;
  logic [XLEN-1:0]   fwd_rs2_s;
  logic [XLEN-1:0]   b_sel_s;
  logic [XLEN-1:0]   aib_s;

  // Youngest producer wins; x0 always reads its architectural zero-source value.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [REG_AW-1:0] src,
    input logic [XLEN-1:0]   reg_data,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_we,
    input logic [XLEN-1:0]   e_res,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we,
    input logic [XLEN-1:0]   w_res
  );
    logic [XLEN-1:0] r;
    if (e_we && (e_rd != {REG_AW{1'b0}}) && (e_rd == src)) begin
      r = e_res;
    end else if (w_we && (w_rd != {REG_AW{1'b0}}) && (w_rd == src)) begin
      r = w_res;
    end else begin
      r = reg_data;
    end
    return r;
  endfunction

  // Load-use hazard detection and bubble decision.
  always_comb begin
    load_use_s = valid_r && mem_read_r && (rd_addr_r != {REG_AW{1'b0}}) && id_valid &&
                 ((id_uses_rs1 && (id_rs1_addr == rd_addr_r)) ||
                  (id_uses_rs2 && (id_rs2_addr == rd_addr_r)));
    bubble_s   = rst || flush || (!stall && load_use_s);
  end

  // Pipeline register: bubble beats hold beats capture.
  always_ff @(posedge clk) begin
    if (bubble_s) begin
      valid_r     <= 1'b0;
      pc_r        <= {XLEN{1'b0}};
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      rs1_addr_r  <= {REG_AW{1'b0}};
      rs2_addr_r  <= {REG_AW{1'b0}};
      rd_addr_r   <= {REG_AW{1'b0}};
      alu_sel_r   <= 5'd0;
      a_pc_r      <= 1'b0;
      b_imm_r     <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (!stall) begin
      valid_r     <= id_valid;
      pc_r        <= id_pc;
      rs1_data_r  <= id_rs1_data;
      rs2_data_r  <= id_rs2_data;
      imm_r       <= id_imm;
      rs1_addr_r  <= id_rs1_addr;
      rs2_addr_r  <= id_rs2_addr;
      rd_addr_r   <= id_rd_addr;
      alu_sel_r   <= id_alu_sel;
      a_pc_r      <= id_a_pc;
      b_imm_r     <= id_b_imm;
      reg_write_r <= id_valid && id_reg_write;
      mem_read_r  <= id_valid && id_mem_read;
      mem_write_r <= id_valid && id_mem_write;
    end else begin
      valid_r     <= valid_r;
    end
  end

  // Operand forwarding and selection; shifts only see a 5-bit amount.
  always_comb begin
    fwd_rs1_s = fwd_pick(rs1_addr_r, rs1_data_r, exm_rd_addr, exm_reg_write, exm_result,
                         wb_rd_addr, wb_reg_write, wb_result);
    fwd_rs2_s = fwd_pick(rs2_addr_r, rs2_data_r, exm_rd_addr, exm_reg_write, exm_result,
                         wb_rd_addr, wb_reg_write, wb_result);
    if (b_imm_r) begin
      b_sel_s = imm_r;
    end else begin
      b_sel_s = fwd_rs2_s;
    end
    case (alu_sel_r)
      ALU_SLL, ALU_SRL, ALU_SRA: aib_s = {{(XLEN-5){1'b0}}, b_sel_s[4:0]};
      default:                   aib_s = b_sel_s;
    endcase
  end

  assign ALUSignal      = alu_sel_r;
  assign AiA            = a_pc_r ? pc_r : fwd_rs1_s;
  assign AiB            = aib_s;
  assign ex_valid       = valid_r;
  assign ex_pc          = pc_r;
  assign ex_store_data  = fwd_rs2_s;
  assign ex_rd_addr     = rd_addr_r;
  assign ex_reg_write   = valid_r && reg_write_r;
  assign ex_mem_read    = valid_r && mem_read_r;
  assign ex_mem_write   = valid_r && mem_write_r;
  assign load_use_stall = load_use_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: an EX-slot record model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs1, id_uses_rs2, id_a_pc, id_b_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, stall, flush;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exm_result, wb_result;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_sel, exm_rd_addr, wb_rd_addr;
  logic [4:0]  ALUSignal, ex_rd_addr;
  logic [31:0] AiA, AiB, ex_pc, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_sel(id_alu_sel),
    .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ALUSignal(ALUSignal), .AiA(AiA), .AiB(AiB), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );

  // What instruction currently occupies the EX slot, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, sel;
    logic        apc, bimm, rw, mr, mw;
  } slot_t;

  slot_t       m;
  logic [31:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value an instruction sees for register a: newest in-flight writer, else the file.
  function automatic logic [31:0] reg_view(input logic [4:0] a, input logic [31:0] file_val);
    if (a == 5'd0) return file_val;
    if (exm_reg_write && exm_rd_addr == a) return exm_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return file_val;
  endfunction

  function automatic logic model_hazard();
    return m.valid && m.mr && (m.rd != 5'd0) && id_valid &&
           ((id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd));
  endfunction

  // Model slot update on each rising edge.
  always @(posedge clk) begin
    if (rst || flush) m <= '0;
    else if (stall) m <= m;
    else if (model_hazard()) m <= '0;
    else m <= '{valid: id_valid, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data,
                imm: id_imm, rs1a: id_rs1_addr, rs2a: id_rs2_addr, rd: id_rd_addr,
                sel: id_alu_sel, apc: id_a_pc, bimm: id_b_imm,
                rw: id_valid & id_reg_write, mr: id_valid & id_mem_read,
                mw: id_valid & id_mem_write};
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_b = m.bimm ? m.imm : reg_view(m.rs2a, m.rs2d);
      if (m.sel == 5'd2 || m.sel == 5'd6 || m.sel == 5'd7) exp_b = exp_b % 32'd32;
      chk("m_alusel", {27'd0, ALUSignal}, {27'd0, m.sel});
      chk("m_aia", AiA, m.apc ? m.pc : reg_view(m.rs1a, m.rs1d));
      chk("m_aib", AiB, exp_b);
      chk("m_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      chk("m_pc", ex_pc, m.pc);
      chk("m_store", ex_store_data, reg_view(m.rs2a, m.rs2d));
      chk("m_rd", {27'd0, ex_rd_addr}, {27'd0, m.rd});
      chk("m_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
          {29'd0, m.rw, m.mr, m.mw});
      chk("m_lus", {31'd0, load_use_stall}, {31'd0, model_hazard()});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0;
    id_imm = 32'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_alu_sel = 5'd0; id_a_pc = 1'b0;
    id_b_imm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    stall = 1'b0; flush = 1'b0;
    exm_rd_addr = 5'd0; exm_reg_write = 1'b0; exm_result = 32'd0;
    wb_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_result = 32'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_alusel", {27'd0, ALUSignal}, 32'd0);
    chk("rst_aia", AiA, 32'd0);
    chk("rst_aib", AiB, 32'd0);
    chk("rst_lus", {31'd0, load_use_stall}, 32'd0);

    // Plain ADD x5, x6
    #1 rst = 1'b0;
    id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_data = 32'h10; id_rs2_addr = 5'd6;
    id_rs2_data = 32'h20; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rd_addr = 5'd1;
    id_reg_write = 1'b1;
    tick();
    chk("add_alusel", {27'd0, ALUSignal}, 32'd0);
    chk("add_aia", AiA, 32'h10);
    chk("add_aib", AiB, 32'h20);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);

    // Forwarding priority on rs1
    #1 idle();
    id_valid = 1'b1; id_rs1_addr = 5'd7; id_rs1_data = 32'h1234; id_uses_rs1 = 1'b1;
    id_b_imm = 1'b1; id_imm = 32'h40; id_rd_addr = 5'd10; id_reg_write = 1'b1;
    tick();
    chk("fw_none", AiA, 32'h1234);
    #1 stall = 1'b1;
    exm_rd_addr = 5'd7; exm_reg_write = 1'b1; exm_result = 32'hAAAA;
    wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_result = 32'hBBBB;
    tick();
    chk("fw_exm", AiA, 32'hAAAA);
    #1 exm_reg_write = 1'b0;
    tick();
    chk("fw_wb", AiA, 32'hBBBB);
    #1 stall = 1'b0; id_rs1_addr = 5'd0; id_rs1_data = 32'h55;
    exm_rd_addr = 5'd0; exm_reg_write = 1'b1; wb_rd_addr = 5'd0;
    tick();
    chk("fw_x0", AiA, 32'h55);
    chk("fw_x0_aib", AiB, 32'h40);

    // Load-use: lw x3 followed by a consumer of x3 via rs2
    #1 idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd3;
    id_rs1_addr = 5'd2; id_rs1_data = 32'h300; id_uses_rs1 = 1'b1;
    id_b_imm = 1'b1; id_imm = 32'd4;
    tick();
    chk("ld_memread", {31'd0, ex_mem_read}, 32'd1);
    chk("ld_aia", AiA, 32'h300);
    #1 id_mem_read = 1'b0; id_rd_addr = 5'd8; id_rs1_addr = 5'd4; id_rs1_data = 32'h100;
    id_uses_rs2 = 1'b1; id_rs2_addr = 5'd3; id_rs2_data = 32'h999; id_b_imm = 1'b0;
    #2 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk("lu_cleared", {31'd0, load_use_stall}, 32'd0);
    #1 wb_rd_addr = 5'd3; wb_reg_write = 1'b1; wb_result = 32'hCAFE;
    tick();
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_aia", AiA, 32'h100);
    chk("lu_aib_wb", AiB, 32'hCAFE);
    chk("lu_store", ex_store_data, 32'hCAFE);

    // SRA with immediate shift amount, then stall hold and flush+stall
    #1 idle();
    id_valid = 1'b1; id_alu_sel = 5'd7; id_rs1_addr = 5'd9; id_rs1_data = 32'h8000_0000;
    id_uses_rs1 = 1'b1; id_b_imm = 1'b1; id_imm = 32'h0000_0FE3; id_rd_addr = 5'd4;
    id_reg_write = 1'b1;
    tick();
    chk("sra_aib", AiB, 32'h3);
    #1 stall = 1'b1; id_imm = 32'h1; id_alu_sel = 5'd0; id_rs1_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_aib", AiB, 32'h3);
      chk("hold_aia", AiA, 32'h8000_0000);
      chk("hold_alusel", {27'd0, ALUSignal}, 32'd7);
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    #1 flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_alusel", {27'd0, ALUSignal}, 32'd0);
    chk("flush_aia", AiA, 32'd0);
    chk("flush_aib", AiB, 32'd0);

    // Valid store held under stall, then reset
    #1 idle();
    id_valid = 1'b1; id_mem_write = 1'b1; id_pc = 32'h1000; id_uses_rs1 = 1'b1;
    id_uses_rs2 = 1'b1; id_rs1_addr = 5'd1; id_rs1_data = 32'h200; id_rs2_addr = 5'd6;
    id_rs2_data = 32'h77; id_b_imm = 1'b1; id_imm = 32'd8;
    tick();
    chk("st_memwrite", {31'd0, ex_mem_write}, 32'd1);
    chk("st_data", ex_store_data, 32'h77);
    chk("st_aib", AiB, 32'd8);
    #1 stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_st_memwrite", {31'd0, ex_mem_write}, 32'd0);
    chk("rst_st_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_st_pc", ex_pc, 32'd0);
    chk("rst_st_data", ex_store_data, 32'd0);
    chk("rst_st_aia", AiA, 32'd0);

    // First edge after reset is normal: a_pc operand, unusual op code passed through
    #1 rst = 1'b0; stall = 1'b0; id_mem_write = 1'b0; id_a_pc = 1'b1;
    id_alu_sel = 5'd12; id_reg_write = 1'b1; id_rd_addr = 5'd2;
    tick();
    chk("post_valid", {31'd0, ex_valid}, 32'd1);
    chk("post_aia_pc", AiA, 32'h1000);
    chk("post_alusel", {27'd0, ALUSignal}, 32'd12);
    chk("post_rw", {31'd0, ex_reg_write}, 32'd1);
    #1 id_valid = 1'b0;
    tick();
    chk("inv_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);

    #1 idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
